vga_timing_monitor: RTL and testbench
=====================================

// Module: vga_timing_monitor
// PURPOSE
// - Receive end of the VGA timing interface: watches hsync/vsync/de from a raster timing generator or an external source.
// - Recovers pixel coordinates, measures line/frame periods, declares lock on a nominal 640x480 (800x525) mode.
// - Flags timing and de errors; used as a checker in benches and as a sink on capture paths.
// PARAMETERS
// - H_TOTAL   800  enable cycles per line
// - H_SYNC    96   hsync pulse width, enable cycles
// - H_START   144  hsync rise to first active pixel (sync+bp)
// - H_ACTIVE  640  active pixels per line
// - V_TOTAL   525  lines per frame
// - V_START   35   vsync rise to first active line (sync+bp)
// - V_ACTIVE  480  active lines per frame
// - LOCK_FRAMES 2  consecutive good frames required for lock
// PORTS
// - clk         in   1   clock
// - reset       in   1   synchronous, active-high reset
// - enable      in   1   pixel strobe; all sampling and counting qualified by it
// - hsync       in   1   horizontal sync, active-high
// - vsync       in   1   vertical sync, active-high, changes only on hsync falling edge
// - de          in   1   data enable (h_active && v_active)
// - x           out  10  recovered column, 0..639 when pixel_valid
// - y           out  10  recovered row, 0..479 when pixel_valid
// - pixel_valid out  1   recovered active region (valid only when locked)
// - locked      out  1   timing lock
// - h_period    out  10  last measured line length, enable cycles
// - v_period    out  10  last measured frame length, lines
// - timing_err  out  1   one-cycle pulse: period/width mismatch or timeout
// - de_err      out  1   one-cycle pulse: de != pixel_valid while locked
// - err_count   out  8   saturating count of timing_err|de_err pulses
// BEHAVIOUR
// - Reset: all outputs 0; hcnt=vcnt=0; state SEARCH; sync history regs 0. Reset mid-frame acts identically.
// - Inputs registered once on enable; edges detected against previous sample. Outputs 1 clk after sampling enable.
// - hcnt counts enable cycles since hsync rise, saturating at 1023. On hsync rise: h_period<=hcnt+1, hcnt<=0.
// - Timeout: hcnt reaching 1023 -> timing_err pulse, state to SEARCH.
// - hsync width counted; on hsync fall, width != H_SYNC -> timing_err.
// - vsync sampled on hsync fall (enable-qualified). vcnt increments on hsync rise, saturating at 1023.
// - vsync rise: v_period<=vcnt+1, vcnt<=0. Same-cycle hsync rise and vsync rise: vsync processed first, line is vcnt=0.
// - Good line: h_period==H_TOTAL. Good frame: every line good and v_period==V_TOTAL.
// - FSM SEARCH: wait first vsync rise -> ACQUIRE with good_frames=0.
// - FSM ACQUIRE: each vsync rise with good frame increments good_frames; ==LOCK_FRAMES -> LOCKED; bad frame -> good_frames=0.
// - FSM LOCKED: any bad line, bad width or bad v_period -> timing_err, locked=0, ACQUIRE (good_frames=0).
// - x = hcnt-H_START, y = vcnt-V_START (10-bit wrap).
// - pixel_valid = locked && hcnt in [H_START,H_START+H_ACTIVE-1] && vcnt in [V_START,V_START+V_ACTIVE-1].
// - de_err only while locked and enable; simultaneous timing_err+de_err counts once.
// - err_count saturates at 255; cleared only by reset.
// - enable low: all state frozen, no pulses generated.
// STRUCTURE
// - Package vga_timing_pkg: H/V timing constants, lock_state_t enum {SEARCH,ACQUIRE,LOCKED}.
//   The same constants drive the raster generator compare tables.
// - Sub-module sync_edge_det: enable-qualified sample reg plus rise/fall pulses; one instance each for hsync, vsync.
// - Top holds hcnt/vcnt, width counter, FSM, error logic.
// TESTING
// - Nominal 800x525 stream, enable=1: locked rises 1 clk after 3rd vsync rise; h_period=800, v_period=525, err_count=0.
// - Locked: 144 cycles after hsync rise, 35 lines after vsync rise -> pixel_valid=1, x=0, y=0.
//   Last active pixel -> x=639, y=479.
// - One line of 801 cycles while locked: timing_err one pulse, locked=0, err_count=1.
//   Relock after 2 clean frames plus vsync rise.
// - Force de=0 on one active pixel: de_err pulse at that pixel; locked stays 1; err_count increments.
// - Hold hsync low 1100 cycles: timing_err at hcnt=1023, state SEARCH, locked=0.
// - enable toggling 50%: same results as nominal, scaled in clk.
//   Assert reset mid-frame: all outputs 0 next clk.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 (800x525) timing constants and lock-state encoding for the
// VGA raster generator and the timing monitor.
package vga_timing_pkg;

  localparam int H_TOTAL_NOM     = 800;
  localparam int H_SYNC_NOM      = 96;
  localparam int H_START_NOM     = 144;
  localparam int H_ACTIVE_NOM    = 640;
  localparam int V_TOTAL_NOM     = 525;
  localparam int V_START_NOM     = 35;
  localparam int V_ACTIVE_NOM    = 480;
  localparam int LOCK_FRAMES_NOM = 2;

  localparam int                CNT_W   = 10;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  typedef enum logic [1:0] {
    SEARCH,
    ACQUIRE,
    LOCKED
  } lock_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/vga_timing_monitor_if.sv
// Raster timing bus: pixel strobe plus sync/data-enable as seen at a receive port.
interface vga_timing_monitor_if;

  logic enable;
  logic hsync;
  logic vsync;
  logic de;

  modport master (output enable, hsync, vsync, de);
  modport slave  (input  enable, hsync, vsync, de);

endinterface

// File: rtl/sync_edge_det.sv
// Enable-qualified sample register with rise/fall pulses taken against the
// previously stored sample.
module sync_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) q <= 1'b0;
    else if (en) q <= d;
  end

  // Edges are visible in the sampling cycle so the consumer acts on the same strobe.
  assign rise = en &  d & ~q;
  assign fall = en & ~d &  q;

endmodule

// File: rtl/vga_timing_monitor.sv
// Receive-side VGA timing checker: recovers x/y, measures line/frame periods,
// declares lock on the configured mode and flags timing and de errors.
module vga_timing_monitor
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL     = H_TOTAL_NOM,
  parameter int H_SYNC      = H_SYNC_NOM,
  parameter int H_START     = H_START_NOM,
  parameter int H_ACTIVE    = H_ACTIVE_NOM,
  parameter int V_TOTAL     = V_TOTAL_NOM,
  parameter int V_START     = V_START_NOM,
  parameter int V_ACTIVE    = V_ACTIVE_NOM,
  parameter int LOCK_FRAMES = LOCK_FRAMES_NOM
) (
  input  logic                 clk,
  input  logic                 reset,
  vga_timing_monitor_if.slave  vga,
  output logic [CNT_W-1:0]     x,
  output logic [CNT_W-1:0]     y,
  output logic                 pixel_valid,
  output logic                 locked,
  output logic [CNT_W-1:0]     h_period,
  output logic [CNT_W-1:0]     v_period,
  output logic                 timing_err,
  output logic                 de_err,
  output logic [7:0]           err_count
);

  localparam logic [CNT_W-1:0] H_TOT   = CNT_W'(H_TOTAL);
  localparam logic [CNT_W-1:0] H_SW    = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] H_FIRST = CNT_W'(H_START);
  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_START + H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_TOT   = CNT_W'(V_TOTAL);
  localparam logic [CNT_W-1:0] V_FIRST = CNT_W'(V_START);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_START + V_ACTIVE - 1);
  localparam logic [7:0]       LOCK_N  = 8'(LOCK_FRAMES);

  logic en;
  logic hs_q, h_rise, h_fall, v_rise, vs_q_unused, v_fall_unused;
  logic [CNT_W-1:0] hcnt, vcnt, hs_width, hcnt_nxt, vcnt_nxt, h_len, v_len;
  logic v_pend, frame_ok;
  logic v_start, line_bad, width_bad, frame_len_bad, timeout, frame_good;
  logic terr, de_mis, pv_nxt;
  lock_state_t state;
  logic [7:0] good_frames;

  assign en = vga.enable;

  sync_edge_det u_hsync_det (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .d    (vga.hsync),
    .q    (hs_q),
    .rise (h_rise),
    .fall (h_fall)
  );

  // vsync only moves with hsync fall, so it is sampled there.
  sync_edge_det u_vsync_det (
    .clk  (clk),
    .reset(reset),
    .en   (en & h_fall),
    .d    (vga.vsync),
    .q    (vs_q_unused),
    .rise (v_rise),
    .fall (v_fall_unused)
  );

  // A vsync rise is held until the next line start, which becomes line 0.
  assign v_start       = h_rise & v_pend;
  assign h_len         = sat_inc(hcnt);
  assign v_len         = sat_inc(vcnt);
  assign line_bad      = h_rise && (h_len != H_TOT);
  assign width_bad     = h_fall && (hs_width != H_SW);
  assign frame_len_bad = v_start && (v_len != V_TOT);
  assign frame_good    = frame_ok && !line_bad && !frame_len_bad;
  assign timeout       = en && !h_rise && (hcnt == CNT_MAX - 1'b1);
  assign terr          = timeout ||
                         ((state == LOCKED) && (line_bad || width_bad || frame_len_bad));

  // NOTE: every comb output gets a default first so no latch is inferred.
  always_comb begin
    hcnt_nxt = sat_inc(hcnt);
    vcnt_nxt = vcnt;
    if (h_rise) hcnt_nxt = '0;
    if (v_start)     vcnt_nxt = '0;
    else if (h_rise) vcnt_nxt = v_len;
  end

  // Lock only changes outside the active window, so the current state is enough here.
  assign pv_nxt = (state == LOCKED) &&
                  (hcnt_nxt >= H_FIRST) && (hcnt_nxt <= H_LAST) &&
                  (vcnt_nxt >= V_FIRST) && (vcnt_nxt <= V_LAST);
  assign de_mis = en && (state == LOCKED) && (vga.de != pv_nxt);

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt        <= '0;
      vcnt        <= '0;
      hs_width    <= '0;
      v_pend      <= 1'b0;
      frame_ok    <= 1'b0;
      state       <= SEARCH;
      good_frames <= '0;
      x           <= '0;
      y           <= '0;
      pixel_valid <= 1'b0;
      locked      <= 1'b0;
      h_period    <= '0;
      v_period    <= '0;
      timing_err  <= 1'b0;
      de_err      <= 1'b0;
      err_count   <= '0;
    end else begin
      timing_err <= terr;
      de_err     <= de_mis;
      if ((terr || de_mis) && (err_count != 8'hFF)) err_count <= err_count + 1'b1;

      if (en) begin
        hcnt        <= hcnt_nxt;
        vcnt        <= vcnt_nxt;
        x           <= hcnt_nxt - H_FIRST;
        y           <= vcnt_nxt - V_FIRST;
        pixel_valid <= pv_nxt;

        if (h_rise) begin
          h_period <= h_len;
          hs_width <= CNT_W'(1);
        end else if (hs_q && vga.hsync) begin
          hs_width <= sat_inc(hs_width);
        end

        if (v_rise)       v_pend <= 1'b1;
        else if (v_start) v_pend <= 1'b0;

        if (v_start) v_period <= v_len;

        if (v_start)                                frame_ok <= 1'b1;
        else if (line_bad || width_bad || timeout)  frame_ok <= 1'b0;

        if (timeout) begin
          state       <= SEARCH;
          locked      <= 1'b0;
          good_frames <= '0;
        end else begin
          case (state)
            SEARCH: if (v_start) begin
              state       <= ACQUIRE;
              good_frames <= '0;
            end
            ACQUIRE: if (v_start) begin
              if (!frame_good) begin
                good_frames <= '0;
              end else if (good_frames + 8'd1 == LOCK_N) begin
                state       <= LOCKED;
                locked      <= 1'b1;
                good_frames <= '0;
              end else begin
                good_frames <= good_frames + 8'd1;
              end
            end
            LOCKED: if (line_bad || width_bad || frame_len_bad) begin
              state       <= ACQUIRE;
              locked      <= 1'b0;
              good_frames <= '0;
            end
            default: state <= SEARCH;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor on a scaled 40x20 raster (24x12 active)
// so several frames fit in a short run; full-rate and half-rate enable.
module tb_vga_timing_monitor;

  localparam int HT = 40, HS = 6, HST = 10, HA = 24;
  localparam int VT = 20, VST = 4, VA = 12;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] x, y, h_period, v_period;
  logic       pixel_valid, locked, timing_err, de_err;
  logic [7:0] err_count;

  vga_timing_monitor_if vif ();

  vga_timing_monitor #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_START(HST), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_START(VST), .V_ACTIVE(VA), .LOCK_FRAMES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .vga        (vif),
    .x          (x),
    .y          (y),
    .pixel_valid(pixel_valid),
    .locked     (locked),
    .h_period   (h_period),
    .v_period   (v_period),
    .timing_err (timing_err),
    .de_err     (de_err),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int l;
    int h;
    int ex;
    int ey;
    int epv;
  } vec_t;

  vec_t tbl[8];
  int   tests = 0;
  int   fails = 0;
  int   pos_l, pos_h;
  bit   half = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic gen_hs(input int l, input int h);
    return h < HS;
  endfunction

  function automatic logic gen_vs(input int l, input int h);
    return (l == VT - 1 && h >= HS) || (l == 0) || (l == 1 && h < HS);
  endfunction

  function automatic logic gen_de(input int l, input int h);
    return (h >= HST) && (h < HST + HA) && (l >= VST) && (l < VST + VA);
  endfunction

  task automatic tick(input logic en, input logic hs, input logic vs, input logic de);
    @(negedge clk);
    vif.enable = en;
    vif.hsync  = hs;
    vif.vsync  = vs;
    vif.de     = de;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cur(input bit de_low);
    if (half) begin
      tick(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
      check("idle_no_pulse", int'(timing_err | de_err), 0);
    end
    tick(1'b1, gen_hs(pos_l, pos_h), gen_vs(pos_l, pos_h),
         de_low ? 1'b0 : gen_de(pos_l, pos_h));
  endtask

  task automatic advance();
    pos_h++;
    if (pos_h == HT) begin
      pos_h = 0;
      pos_l = (pos_l + 1) % VT;
    end
  endtask

  task automatic step();
    drive_cur(1'b0);
    advance();
  endtask

  task automatic run_to(input int l, input int h);
    for (int n = 0; n <= HT * VT && !(pos_l == l && pos_h == h); n++) step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_x"}, x, 0);
    check({tag, "_y"}, y, 0);
    check({tag, "_pv"}, pixel_valid, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_hper"}, h_period, 0);
    check({tag, "_vper"}, v_period, 0);
    check({tag, "_terr"}, timing_err, 0);
    check({tag, "_deerr"}, de_err, 0);
    check({tag, "_errcnt"}, err_count, 0);
  endtask

  // Lock comes exactly one clock after the third processed vsync rise.
  task automatic acquire_lock(input string tag);
    run_to(0, 0);
    step();
    check({tag, "_lock_vs1"}, locked, 0);
    run_to(0, 0);
    step();
    check({tag, "_lock_vs2"}, locked, 0);
    run_to(0, 0);
    check({tag, "_lock_pre3"}, locked, 0);
    step();
    check({tag, "_lock_vs3"}, locked, 1);
    check({tag, "_hper"}, h_period, HT);
    check({tag, "_vper"}, v_period, VT);
    check({tag, "_errcnt"}, err_count, 0);
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < 8; i++) begin
      run_to(tbl[i].l, tbl[i].h);
      step();
      check($sformatf("%s_x[%0d]", tag, i), x, tbl[i].ex);
      check($sformatf("%s_y[%0d]", tag, i), y, tbl[i].ey);
      check($sformatf("%s_pv[%0d]", tag, i), pixel_valid, tbl[i].epv);
      check($sformatf("%s_deerr[%0d]", tag, i), de_err, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int first_k, pulses;

    tbl[0] = '{l: 3,  h: 10, ex: 0,    ey: 1023, epv: 0};
    tbl[1] = '{l: 4,  h: 9,  ex: 1023, ey: 0,    epv: 0};
    tbl[2] = '{l: 4,  h: 10, ex: 0,    ey: 0,    epv: 1};
    tbl[3] = '{l: 4,  h: 34, ex: 24,   ey: 0,    epv: 0};
    tbl[4] = '{l: 10, h: 20, ex: 10,   ey: 6,    epv: 1};
    tbl[5] = '{l: 15, h: 33, ex: 23,   ey: 11,   epv: 1};
    tbl[6] = '{l: 16, h: 10, ex: 0,    ey: 12,   epv: 0};
    tbl[7] = '{l: 0,  h: 0,  ex: 1014, ey: 1020, epv: 0};

    reset = 1'b1;
    vif.enable = 1'b0;
    vif.hsync  = 1'b0;
    vif.vsync  = 1'b0;
    vif.de     = 1'b0;
    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
    check_all_zero("reset");
    @(negedge clk) reset = 1'b0;

    // Full-rate enable
    pos_l = VT - 1;
    pos_h = 0;
    acquire_lock("full");
    run_table("full");

    // One line stretched by a cycle while locked
    run_to(17, HT - 1);
    drive_cur(1'b0);
    step();
    step();
    check("long_terr", timing_err, 1);
    check("long_locked", locked, 0);
    check("long_errcnt", err_count, 1);
    check("long_hper", h_period, HT + 1);
    step();
    check("long_terr_one_pulse", timing_err, 0);
    run_to(0, 0);
    step();
    check("relock_bad_frame", locked, 0);
    check("relock_vper", v_period, VT);
    run_to(0, 0);
    step();
    check("relock_clean1", locked, 0);
    run_to(0, 0);
    step();
    check("relock_clean2", locked, 1);

    // de dropped on one active pixel
    run_to(6, 15);
    drive_cur(1'b1);
    advance();
    check("de_err_pulse", de_err, 1);
    check("de_err_locked", locked, 1);
    check("de_err_errcnt", err_count, 2);
    check("de_err_x", x, 5);
    check("de_err_y", y, 2);
    step();
    check("de_err_one_pulse", de_err, 0);

    // hsync held low: timeout when hcnt reaches 1023 (hcnt starts this hold at HT-1)
    run_to(17, 0);
    first_k = -1;
    pulses  = 0;
    for (int k = 1; k <= 1100; k++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      if (timing_err) begin
        pulses++;
        if (first_k < 0) first_k = k;
      end
    end
    check("timeout_pulses", pulses, 1);
    check("timeout_at", first_k, 1023 - (HT - 1));
    check("timeout_locked", locked, 0);
    check("timeout_errcnt", err_count, 3);

    // Half-rate enable after a fresh reset
    @(negedge clk) reset = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    check_all_zero("reset2");
    @(negedge clk) reset = 1'b0;
    half  = 1'b1;
    pos_l = VT - 1;
    pos_h = 0;
    acquire_lock("half");
    run_table("half");

    // Reset in the middle of the active region
    run_to(8, 15);
    step();
    check("mid_pv", pixel_valid, 1);
    check("mid_x", x, 5);
    check("mid_y", y, 4);
    @(negedge clk);
    reset = 1'b1;
    vif.enable = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("midrst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
